// File: rtl/dec_seq_pkg.sv
// Shared definitions for the SCM16 decode/sequencer block: mode encodings
// and a bounded one-hot helper used by every decoder instance.
package dec_seq_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_OFF    = 2'd0;
  localparam mode_t MODE_DIRECT = 2'd1;
  localparam mode_t MODE_STEP   = 2'd2;
  localparam mode_t MODE_PULSE  = 2'd3;

  localparam int MAX_OUT = 64;

  // Callers truncate the result to their own N_OUT; indices at or above n_out decode to zero.
  function automatic logic [MAX_OUT-1:0] onehot(input logic [5:0] sel, input logic [6:0] n_out);
    logic [MAX_OUT-1:0] v;
    v = {MAX_OUT{1'b0}};
    if ({1'b0, sel} < n_out) begin
      v[sel] = 1'b1;
    end else begin
      v = {MAX_OUT{1'b0}};
    end
    return v;
  endfunction

endpackage

// File: rtl/onehot_dec.sv
// Combinational SEL_W -> N_OUT one-hot decoder with an in-range flag.
module onehot_dec
  import dec_seq_pkg::*;
#(
  parameter int SEL_W = 4,
  parameter int N_OUT = 16
) (
  input  logic [SEL_W-1:0] sel_i,
  output logic [N_OUT-1:0] oh_o,
  output logic             in_range_o
);

  localparam logic [6:0] N_OUT_W = 7'(N_OUT);

  assign oh_o       = N_OUT'(onehot(6'(sel_i), N_OUT_W));
  assign in_range_o = ({1'b0, 6'(sel_i)} < N_OUT_W);

endmodule

// File: rtl/dec_seq.sv
// Registered one-hot decoder with OFF / DIRECT / STEP ring / PULSE modes;
// drives SCM16 unit enables and microcode timing phases.
module dec_seq
  import dec_seq_pkg::*;
#(
  parameter int SEL_W = 4,
  parameter int N_OUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode,
  input  logic [SEL_W-1:0] sel,
  input  logic             load,
  input  logic             adv,
  input  logic [SEL_W-1:0] wrap,
  input  logic             dis,
  output logic [N_OUT-1:0] out,
  output logic [SEL_W-1:0] idx,
  output logic             valid,
  output logic             wrapped
);

  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(N_OUT - 1);

  logic [SEL_W-1:0] idx_q, idx_d;
  logic [N_OUT-1:0] out_q, out_d;
  logic             valid_q, valid_d;
  logic             wrapped_q, wrapped_d;
  logic             load_q;

  logic [SEL_W-1:0] wrap_eff_s;
  logic             show_s;
  logic [N_OUT-1:0] dec_oh_s;
  logic             dec_in_range_s;

  assign wrap_eff_s = (wrap > LAST_IDX) ? LAST_IDX : wrap;

  // The single decoder looks at the next index, so out and idx always update together.
  onehot_dec #(
    .SEL_W(SEL_W),
    .N_OUT(N_OUT)
  ) u_dec (
    .sel_i      (idx_d),
    .oh_o       (dec_oh_s),
    .in_range_o (dec_in_range_s)
  );

  always_comb begin
    idx_d     = idx_q;
    show_s    = 1'b0;
    wrapped_d = 1'b0;
    if (dis) begin
      idx_d  = idx_q;
      show_s = 1'b0;
    end else begin
      case (mode)
        MODE_DIRECT: begin
          idx_d  = sel;
          show_s = 1'b1;
        end
        MODE_STEP: begin
          show_s = 1'b1;
          if (load) begin
            idx_d = (sel <= wrap_eff_s) ? sel : {SEL_W{1'b0}};
          end else if (adv && (idx_q >= wrap_eff_s)) begin
            // >= also pulls back an index stranded above a freshly lowered wrap point.
            idx_d     = {SEL_W{1'b0}};
            wrapped_d = 1'b1;
          end else if (adv) begin
            idx_d = idx_q + SEL_W'(1);
          end else begin
            idx_d = idx_q;
          end
        end
        MODE_PULSE: begin
          if (load && !load_q) begin
            idx_d  = sel;
            show_s = 1'b1;
          end else begin
            idx_d  = idx_q;
            show_s = 1'b0;
          end
        end
        default: begin
          idx_d  = idx_q;
          show_s = 1'b0;
        end
      endcase
    end
    out_d   = show_s ? dec_oh_s : {N_OUT{1'b0}};
    valid_d = show_s & dec_in_range_s;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_q     <= {SEL_W{1'b0}};
      out_q     <= {N_OUT{1'b0}};
      valid_q   <= 1'b0;
      wrapped_q <= 1'b0;
      load_q    <= 1'b0;
    end else begin
      idx_q     <= idx_d;
      out_q     <= out_d;
      valid_q   <= valid_d;
      wrapped_q <= wrapped_d;
      load_q    <= load;
    end
  end

  assign out     = out_q;
  assign idx     = idx_q;
  assign valid   = valid_q;
  assign wrapped = wrapped_q;

endmodule

// File: tb/tb_dec_seq.sv
// Scoreboard bench for dec_seq (SEL_W=4, N_OUT=12): the driver queues the
// hand-computed response of each cycle, the monitor checks it after the edge.
module tb_dec_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  mode;
  logic [3:0]  sel;
  logic        load;
  logic        adv;
  logic [3:0]  wrap;
  logic        dis;
  logic [11:0] out;
  logic [3:0]  idx;
  logic        valid;
  logic        wrapped;

  typedef struct {
    string       name;
    logic [11:0] out;
    logic [3:0]  idx;
    logic        valid;
    logic        wrapped;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;

  dec_seq #(.SEL_W(4), .N_OUT(12)) dut (
    .clk(clk), .rst(rst), .mode(mode), .sel(sel), .load(load), .adv(adv),
    .wrap(wrap), .dis(dis), .out(out), .idx(idx), .valid(valid), .wrapped(wrapped)
  );

  always #5 clk = ~clk;

  task automatic compare(input string name, input logic [11:0] eo, input logic [3:0] ei,
                         input logic ev, input logic ew);
    checks++;
    if (out !== eo || idx !== ei || valid !== ev || wrapped !== ew) begin
      errors++;
      $display("FAIL %s: got out=%h idx=%0d valid=%b wrapped=%b, expected out=%h idx=%0d valid=%b wrapped=%b",
               name, out, idx, valid, wrapped, eo, ei, ev, ew);
    end
  endtask

  task automatic drive_push(input string name, input logic [1:0] m, input logic [3:0] s,
                            input logic ld, input logic a, input logic [3:0] w, input logic d,
                            input logic [11:0] eo, input logic [3:0] ei, input logic ev, input logic ew);
    exp_t e;
    mode = m; sel = s; load = ld; adv = a; wrap = w; dis = d;
    e.name = name; e.out = eo; e.idx = ei; e.valid = ev; e.wrapped = ew;
    sb_q.push_back(e);
  endtask

  task automatic cyc(input string name, input logic [1:0] m, input logic [3:0] s,
                     input logic ld, input logic a, input logic [3:0] w, input logic d,
                     input logic [11:0] eo, input logic [3:0] ei, input logic ev, input logic ew);
    @(negedge clk);
    drive_push(name, m, s, ld, a, w, d, eo, ei, ev, ew);
  endtask

  // Monitor: every registered result is checked one step after the edge that produced it.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        exp_t e;
        e = sb_q.pop_front();
        compare(e.name, e.out, e.idx, e.valid, e.wrapped);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: got still running, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0; mode = 2'd0; sel = 4'd0; load = 1'b0; adv = 1'b0; wrap = 4'd0; dis = 1'b0;
    #3;
    compare("reset", 12'h000, 4'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;

    cyc("off_idle", 2'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 12'h000, 4'd0, 1'b0, 1'b0);

    for (int s = 0; s < 16; s++) begin
      logic [11:0] eo;
      eo = (s < 12) ? (12'd1 << s) : 12'd0;
      cyc($sformatf("direct_sel%0d", s), 2'd1, 4'(s), 1'b0, 1'b0, 4'd0, 1'b0,
          eo, 4'(s), (s < 12), 1'b0);
    end

    cyc("off_hold",   2'd0, 4'd3, 1'b0, 1'b0, 4'd0, 1'b0, 12'h000, 4'd15, 1'b0, 1'b0);
    cyc("dis_direct", 2'd1, 4'd2, 1'b0, 1'b0, 4'd0, 1'b1, 12'h000, 4'd15, 1'b0, 1'b0);

    cyc("step_load3", 2'd2, 4'd3, 1'b1, 1'b0, 4'd5, 1'b0, 12'h008, 4'd3, 1'b1, 1'b0);
    cyc("step_adv4",  2'd2, 4'd0, 1'b0, 1'b1, 4'd5, 1'b0, 12'h010, 4'd4, 1'b1, 1'b0);
    cyc("step_adv5",  2'd2, 4'd0, 1'b0, 1'b1, 4'd5, 1'b0, 12'h020, 4'd5, 1'b1, 1'b0);
    cyc("step_wrap0", 2'd2, 4'd0, 1'b0, 1'b1, 4'd5, 1'b0, 12'h001, 4'd0, 1'b1, 1'b1);
    cyc("step_adv1",  2'd2, 4'd0, 1'b0, 1'b1, 4'd5, 1'b0, 12'h002, 4'd1, 1'b1, 1'b0);
    cyc("step_adv2",  2'd2, 4'd0, 1'b0, 1'b1, 4'd5, 1'b0, 12'h004, 4'd2, 1'b1, 1'b0);
    cyc("step_hold2", 2'd2, 4'd0, 1'b0, 1'b0, 4'd5, 1'b0, 12'h004, 4'd2, 1'b1, 1'b0);

    cyc("step_ld_oor",  2'd2, 4'd9, 1'b1, 1'b1, 4'd4, 1'b0, 12'h001, 4'd0, 1'b1, 1'b0);
    cyc("step_ld_prio", 2'd2, 4'd2, 1'b1, 1'b1, 4'd4, 1'b0, 12'h004, 4'd2, 1'b1, 1'b0);

    cyc("clamp_ld11",  2'd2, 4'd11, 1'b1, 1'b0, 4'd15, 1'b0, 12'h800, 4'd11, 1'b1, 1'b0);
    cyc("clamp_wrap",  2'd2, 4'd0,  1'b0, 1'b1, 4'd15, 1'b0, 12'h001, 4'd0,  1'b1, 1'b1);
    cyc("clamp_ld12",  2'd2, 4'd12, 1'b1, 1'b0, 4'd15, 1'b0, 12'h001, 4'd0,  1'b1, 1'b0);
    cyc("midwrap_ld4", 2'd2, 4'd4,  1'b1, 1'b0, 4'd15, 1'b0, 12'h010, 4'd4,  1'b1, 1'b0);
    cyc("midwrap_adv", 2'd2, 4'd0,  1'b0, 1'b1, 4'd2,  1'b0, 12'h001, 4'd0,  1'b1, 1'b1);

    cyc("pulse_rise6",  2'd3, 4'd6, 1'b1, 1'b0, 4'd0, 1'b0, 12'h040, 4'd6, 1'b1, 1'b0);
    cyc("pulse_held1",  2'd3, 4'd6, 1'b1, 1'b0, 4'd0, 1'b0, 12'h000, 4'd6, 1'b0, 1'b0);
    cyc("pulse_held2",  2'd3, 4'd6, 1'b1, 1'b0, 4'd0, 1'b0, 12'h000, 4'd6, 1'b0, 1'b0);
    cyc("pulse_held3",  2'd3, 4'd6, 1'b1, 1'b0, 4'd0, 1'b0, 12'h000, 4'd6, 1'b0, 1'b0);
    cyc("pulse_low",    2'd3, 4'd6, 1'b0, 1'b0, 4'd0, 1'b0, 12'h000, 4'd6, 1'b0, 1'b0);
    cyc("pulse_rise3",  2'd3, 4'd3, 1'b1, 1'b0, 4'd0, 1'b0, 12'h008, 4'd3, 1'b1, 1'b0);
    cyc("pulse_held4",  2'd3, 4'd3, 1'b1, 1'b0, 4'd0, 1'b0, 12'h000, 4'd3, 1'b0, 1'b0);
    cyc("pulse_low2",   2'd3, 4'd13, 1'b0, 1'b0, 4'd0, 1'b0, 12'h000, 4'd3, 1'b0, 1'b0);
    cyc("pulse_oor13",  2'd3, 4'd13, 1'b1, 1'b0, 4'd0, 1'b0, 12'h000, 4'd13, 1'b0, 1'b0);

    cyc("dis_ld3",   2'd2, 4'd3, 1'b1, 1'b0, 4'd15, 1'b0, 12'h008, 4'd3, 1'b1, 1'b0);
    cyc("dis_on1",   2'd2, 4'd0, 1'b0, 1'b1, 4'd15, 1'b1, 12'h000, 4'd3, 1'b0, 1'b0);
    cyc("dis_on2",   2'd2, 4'd0, 1'b0, 1'b1, 4'd15, 1'b1, 12'h000, 4'd3, 1'b0, 1'b0);
    cyc("dis_on3",   2'd2, 4'd0, 1'b0, 1'b1, 4'd15, 1'b1, 12'h000, 4'd3, 1'b0, 1'b0);
    cyc("dis_off",   2'd2, 4'd0, 1'b0, 1'b1, 4'd15, 1'b0, 12'h010, 4'd4, 1'b1, 1'b0);

    cyc("rst_pre_ld7", 2'd2, 4'd7, 1'b1, 1'b0, 4'd15, 1'b0, 12'h080, 4'd7, 1'b1, 1'b0);
    @(negedge clk);
    mode = 2'd2; sel = 4'd0; load = 1'b0; adv = 1'b1; wrap = 4'd15; dis = 1'b0;
    #2 rst = 1'b0;
    #1 compare("rst_async", 12'h000, 4'd0, 1'b0, 1'b0);
    @(posedge clk);
    #1 compare("rst_hold", 12'h000, 4'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    drive_push("rst_first_edge", 2'd2, 4'd0, 1'b0, 1'b1, 4'd15, 1'b0, 12'h002, 4'd1, 1'b1, 1'b0);
    cyc("rst_second_edge", 2'd2, 4'd0, 1'b0, 1'b1, 4'd15, 1'b0, 12'h004, 4'd2, 1'b1, 1'b0);

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending entries, expected 0", sb_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
